// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared constants and types for the three-channel timer.
//                Holds the channel mode encodings, the control-register
//                select code, the control field geometry and a field helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

  localparam int NUM_CH  = 3;
  localparam int CTRL_FW = 2;                 // mode field width per channel
  localparam int CTRL_W  = NUM_CH * CTRL_FW;  // full control register width

  typedef enum logic [CTRL_FW-1:0] {
    MODE_ONESHOT  = 2'b00,
    MODE_RATE     = 2'b01,
    MODE_SQUARE   = 2'b10,
    MODE_DISABLED = 2'b11
  } mode_e;

  // counter_ch value that targets the control register instead of a channel
  localparam logic [1:0] CH_CTRL = 2'd3;

  // Every channel comes out of reset disabled
  localparam logic [CTRL_W-1:0] CTRL_RST = '1;

  // Extract the mode field of one channel from a control word
  function automatic logic [CTRL_FW-1:0] ctrl_field(input logic [CTRL_W-1:0] ctrl,
                                                    input int               ch);
    return ctrl[ch*CTRL_FW +: CTRL_FW];
  endfunction

endpackage
`default_nettype wire

// File: rtl/timer_counter_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : timer_counter_unit_if
//  Description : Bus-side signal bundle between the I/O decoder and the timer.
//                master : bus decoder (drives write strobe/select/data)
//                slave  : timer (drives readback word and channel outputs)
//  Signals     : counter_we   write strobe, one cycle per write
//                counter_ch   0..2 channel, 3 control register
//                counter_val  write data
//                counter_out  readback of selected channel / control
//                counterN_out channel N output bit
//  Revision    : 1.0 - initial release
// ============================================================================
interface timer_counter_unit_if #(
  parameter int WIDTH = 32
);
  logic             counter_we;
  logic [1:0]       counter_ch;
  logic [WIDTH-1:0] counter_val;
  logic [WIDTH-1:0] counter_out;
  logic             counter0_out;
  logic             counter1_out;
  logic             counter2_out;

  modport master (
    output counter_we, counter_ch, counter_val,
    input  counter_out, counter0_out, counter1_out, counter2_out
  );

  modport slave (
    input  counter_we, counter_ch, counter_val,
    output counter_out, counter0_out, counter1_out, counter2_out
  );
endinterface
`default_nettype wire

// File: rtl/timer_channel.sv
`default_nettype none
// ============================================================================
//  Module      : timer_channel
//  Description : One timer channel: tick synchroniser + rising-edge detect,
//                load/count/out registers and the per-mode count behaviour.
//  Ports       : clk       system clock
//                rst       asynchronous reset, active-low
//                tick_raw  asynchronous count source
//                mode      current channel mode from the control register
//                mode_chg  control write changes this channel's mode
//                wr        channel write strobe
//                wr_val    channel write data (load and count)
//                count     current count value
//                out       channel output, straight from a flop
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2   // must be at least 2
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             tick_raw,
  input  wire mode_e            mode,
  input  wire logic             mode_chg,
  input  wire logic             wr,
  input  wire logic [WIDTH-1:0] wr_val,
  output logic      [WIDTH-1:0] count,
  output logic                  out
);

  localparam logic [WIDTH-1:0] c_one = 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [WIDTH-1:0]       r_load;
  logic [WIDTH-1:0]       r_count;
  logic                   r_out;
  logic                   w_tick;

  // One-cycle pulse on each synchronised rising edge; falling edges ignored
  assign w_tick = r_sync[SYNC_STAGES-1] & ~r_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync  <= '0;
      r_prev  <= 1'b0;
      r_load  <= '0;
      r_count <= '0;
      r_out   <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], tick_raw};
      r_prev <= r_sync[SYNC_STAGES-1];

      // A write or mode change always beats a same-cycle tick
      if (wr) begin
        r_load  <= wr_val;
        r_count <= wr_val;
        r_out   <= 1'b0;
      end else if (mode_chg) begin
        r_count <= r_load;
        r_out   <= 1'b0;
      end else begin
        case (mode)
          MODE_ONESHOT: begin
            // count of 1 or 0 both land on 0 with a sticky output
            if (w_tick) begin
              if (r_count > c_one) begin
                r_count <= r_count - c_one;
              end else begin
                r_count <= '0;
                r_out   <= 1'b1;
              end
            end
          end
          MODE_RATE: begin
            // Output is a single-cycle strobe, so it clears every cycle
            r_out <= 1'b0;
            if (w_tick) begin
              if (r_count > c_one) begin
                r_count <= r_count - c_one;
              end else if (r_count == c_one) begin
                r_count <= r_load;
                r_out   <= 1'b1;
              end
            end
          end
          MODE_SQUARE: begin
            // A zero count (load of 0) stalls rather than wrapping
            if (w_tick) begin
              if (r_count > c_one) begin
                r_count <= r_count - c_one;
              end else if (r_count == c_one) begin
                r_count <= r_load;
                r_out   <= ~r_out;
              end
            end
          end
          MODE_DISABLED: begin
            // ticks discarded, state held
          end
        endcase
      end
    end
  end

  assign count = r_count;
  assign out   = r_out;

endmodule
`default_nettype wire

// File: rtl/timer_counter_unit.sv
`default_nettype none
// ============================================================================
//  Module      : timer_counter_unit
//  Description : Three-channel programmable down-counter/timer peripheral.
//                Holds the control register, decodes bus writes to channels
//                and control, and muxes the readback word.
//  Ports       : clk       system clock
//                rst       asynchronous reset, active-low
//                cnt_tick  raw count sources for channels 2..0
//                bus       timer_counter_unit_if.slave bus bundle
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_counter_unit
  import timer_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic [NUM_CH-1:0] cnt_tick,
  timer_counter_unit_if.slave    bus
);

  logic [CTRL_W-1:0] r_ctrl;
  logic              w_ctrl_wr;
  logic [WIDTH-1:0]  w_count [NUM_CH];
  logic [NUM_CH-1:0] w_out;
  logic [WIDTH-1:0]  w_rd;

  assign w_ctrl_wr = bus.counter_we && (bus.counter_ch == CH_CTRL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctrl <= CTRL_RST;
    end else if (w_ctrl_wr) begin
      r_ctrl <= bus.counter_val[CTRL_W-1:0];
    end
  end

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic  w_wr;
      logic  w_mode_chg;
      mode_e w_mode;

      assign w_wr       = bus.counter_we && (bus.counter_ch == 2'(i));
      assign w_mode     = mode_e'(ctrl_field(r_ctrl, i));
      // Only channels whose field actually changes get reloaded
      assign w_mode_chg = w_ctrl_wr &&
                          (ctrl_field(bus.counter_val[CTRL_W-1:0], i) != ctrl_field(r_ctrl, i));

      timer_channel #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
      ) u_channel (
        .clk      (clk),
        .rst      (rst),
        .tick_raw (cnt_tick[i]),
        .mode     (w_mode),
        .mode_chg (w_mode_chg),
        .wr       (w_wr),
        .wr_val   (bus.counter_val),
        .count    (w_count[i]),
        .out      (w_out[i])
      );
    end
  endgenerate

  // Readback is forced to zero while reset is held, whatever the select
  always_comb begin
    w_rd = '0;
    if (rst) begin
      case (bus.counter_ch)
        2'd0:    w_rd = w_count[0];
        2'd1:    w_rd = w_count[1];
        2'd2:    w_rd = w_count[2];
        default: w_rd = {{(WIDTH-CTRL_W){1'b0}}, r_ctrl};
      endcase
    end
  end

  assign bus.counter_out  = w_rd;
  assign bus.counter0_out = w_out[0];
  assign bus.counter1_out = w_out[1];
  assign bus.counter2_out = w_out[2];

endmodule
`default_nettype wire
